// File: rtl/usb_tx_pkt_ctrl.sv
// USB transmit packet sequencer: PID, FIFO payload, inverted CRC16.
// Drives a byte-serial encoder through a valid/ready handshake.
module usb_tx_pkt_ctrl #(
    parameter int MAXPKT = 64,
    parameter int LENW   = 7
) (
    input  logic            clk,
    input  logic            n_rst,
    input  logic            start_tx,
    input  logic [3:0]      pid,
    input  logic [LENW-1:0] pkt_len,
    input  logic [7:0]      fifo_r_data,
    input  logic            fifo_empty,
    output logic            fifo_r_enable,
    output logic [7:0]      tx_byte,
    output logic            tx_valid,
    input  logic            tx_ready,
    output logic            tx_last,
    output logic            tx_abort,
    output logic            busy,
    output logic            done,
    output logic            err
);

    typedef enum logic [2:0] {
        S_IDLE, S_PID, S_DATA, S_CRC_LO, S_CRC_HI, S_DONE
    } state_t;

    state_t          state, state_nx;
    logic [3:0]      pid_q;
    logic [LENW-1:0] len_q, cnt_q;
    logic [15:0]     crc_q;
    logic            err_q;
    logic            illegal;
    logic            req_ok;

    function automatic logic [15:0] crc16_byte(input logic [15:0] c,
                                               input logic [7:0]  b);
        logic [15:0] r;
        r = c ^ {8'h00, b};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        return r;
    endfunction

    assign illegal = (pid[1:0] == 2'b01) ||
                     (pid[1:0] == 2'b11 && pkt_len > LENW'(MAXPKT));
    assign req_ok  = (state == S_IDLE) && start_tx && !illegal;

    always_comb begin
        state_nx      = state;
        tx_byte       = 8'h00;
        tx_valid      = 1'b0;
        tx_last       = 1'b0;
        fifo_r_enable = 1'b0;
        tx_abort      = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (req_ok) state_nx = S_PID;
            end
            S_PID: begin
                tx_byte  = {~pid_q, pid_q};
                tx_valid = 1'b1;
                // only handshake/special PIDs (bit0=0) end after one byte
                tx_last  = ~pid_q[0];
                if (tx_ready) begin
                    if (!pid_q[0])          state_nx = S_DONE;
                    else if (len_q != '0)   state_nx = S_DATA;
                    else                    state_nx = S_CRC_LO;
                end
            end
            S_DATA: begin
                tx_byte  = fifo_r_data;
                tx_valid = ~fifo_empty;
                if (fifo_empty) begin
                    tx_abort = 1'b1;
                    state_nx = S_IDLE;
                end else if (tx_ready) begin
                    fifo_r_enable = 1'b1;
                    if (cnt_q + LENW'(1) == len_q) state_nx = S_CRC_LO;
                end
            end
            S_CRC_LO: begin
                tx_byte  = ~crc_q[7:0];
                tx_valid = 1'b1;
                if (tx_ready) state_nx = S_CRC_HI;
            end
            S_CRC_HI: begin
                tx_byte  = ~crc_q[15:8];
                tx_valid = 1'b1;
                tx_last  = 1'b1;
                if (tx_ready) state_nx = S_DONE;
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);
    assign err  = err_q | ((state == S_DATA) & fifo_empty);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= S_IDLE;
            pid_q <= 4'h0;
            len_q <= '0;
            cnt_q <= '0;
            crc_q <= 16'hFFFF;
            err_q <= 1'b0;
        end else begin
            state <= state_nx;
            err_q <= (state == S_IDLE) && start_tx && illegal;
            if (req_ok) begin
                pid_q <= pid;
                len_q <= pkt_len;
                cnt_q <= '0;
                crc_q <= 16'hFFFF;
            end else if (fifo_r_enable) begin
                cnt_q <= cnt_q + LENW'(1);
                crc_q <= crc16_byte(crc_q, fifo_r_data);
            end
        end
    end

endmodule

// File: tb/tb_usb_tx_pkt_ctrl.sv
// Randomized bench for usb_tx_pkt_ctrl against a packet-level model.
// FIFO and encoder are modelled behaviourally.
module tb_usb_tx_pkt_ctrl;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       start_tx = 1'b0;
    logic [3:0] pid = 4'h0;
    logic [6:0] pkt_len = 7'd0;
    logic [7:0] fifo_r_data;
    logic       fifo_empty;
    logic       fifo_r_enable;
    logic [7:0] tx_byte;
    logic       tx_valid;
    logic       tx_ready = 1'b0;
    logic       tx_last;
    logic       tx_abort;
    logic       busy;
    logic       done;
    logic       err;

    int total = 0;
    int bad = 0;
    int rmode = 0;

    usb_tx_pkt_ctrl #(.MAXPKT(64), .LENW(7)) dut (
        .clk(clk), .n_rst(n_rst), .start_tx(start_tx), .pid(pid),
        .pkt_len(pkt_len), .fifo_r_data(fifo_r_data),
        .fifo_empty(fifo_empty), .fifo_r_enable(fifo_r_enable),
        .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_last(tx_last), .tx_abort(tx_abort), .busy(busy),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // show-ahead FIFO model
    logic [7:0] fmem [256];
    logic [7:0] frd = 8'd0;
    logic [7:0] fwr = 8'd0;
    assign fifo_empty  = (frd == fwr);
    assign fifo_r_data = fmem[frd];
    always @(posedge clk) if (fifo_r_enable) frd <= frd + 8'd1;

    always @(posedge clk) begin
        #1;
        case (rmode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = ~tx_ready;
            default: tx_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // monitor: everything here is counted, only the bench tasks compare
    logic [7:0] got_q [$];
    bit         last_q [$];
    int pops = 0, pop_bad = 0, stab_bad = 0;
    int n_err = 0, n_abort = 0, n_done = 0, n_errab = 0, busy_cnt = 0;
    logic       stall_prev = 1'b0;
    logic [7:0] pb;
    logic       pv, pl;

    always @(negedge clk) begin
        if (!n_rst) begin
            stall_prev = 1'b0;
        end else begin
            if (tx_valid && tx_ready) begin
                got_q.push_back(tx_byte);
                last_q.push_back(tx_last);
            end
            if (fifo_r_enable) begin
                pops++;
                if (!(tx_valid && tx_ready)) pop_bad++;
            end
            if (done) n_done++;
            if (err) n_err++;
            if (tx_abort) n_abort++;
            if (err && tx_abort) n_errab++;
            if (busy) busy_cnt++;
            if (stall_prev && (tx_byte !== pb || tx_valid !== pv ||
                               tx_last !== pl)) stab_bad++;
            stall_prev = tx_valid && !tx_ready;
            pb = tx_byte;
            pv = tx_valid;
            pl = tx_last;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // bit-serial, LSB-first CRC16 with reflected 0x8005
    function automatic logic [15:0] ref_crc(input logic [7:0] d[$],
                                            input int n);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int i = 0; i < n; i++)
            for (int k = 0; k < 8; k++) begin
                fb = d[i][k] ^ c[0];
                c  = c >> 1;
                if (fb) c = c ^ 16'hA001;
            end
        return c;
    endfunction

    task automatic load_fifo(input int n, input int dm,
                             output logic [7:0] d[$]);
        logic [7:0] b;
        d   = {};
        fwr = frd;
        for (int i = 0; i < n; i++) begin
            b = (dm == 1) ? 8'(i) : (dm == 2) ? 8'hAA : 8'($urandom);
            fmem[fwr] = b;
            fwr = fwr + 8'd1;
            d.push_back(b);
        end
    endtask

    task automatic run_pkt(input logic [3:0] p, input int len,
                           input int navail, input int rm, input int dm,
                           input bit poke);
        logic [7:0] d [$];
        logic [7:0] eq [$];
        logic [15:0] c;
        bit legal, e_err, e_ab, e_done, to;
        int e_pops, n, m;
        int g0, p0, pb0, sb0, er0, ab0, dn0, ea0, bz0;
        load_fifo(navail, dm, d);
        legal  = !(p[1:0] == 2'b01 || (p[1:0] == 2'b11 && len > 64));
        e_err  = !legal;
        e_ab   = 1'b0;
        e_done = 1'b0;
        e_pops = 0;
        if (legal) begin
            eq.push_back({~p, p});
            if (!p[0]) begin
                e_done = 1'b1;
            end else begin
                n = (len < navail) ? len : navail;
                for (int i = 0; i < n; i++) eq.push_back(d[i]);
                e_pops = n;
                if (navail < len) begin
                    e_err = 1'b1;
                    e_ab  = 1'b1;
                end else begin
                    c = ref_crc(d, len);
                    eq.push_back(~c[7:0]);
                    eq.push_back(~c[15:8]);
                    e_done = 1'b1;
                end
            end
        end
        g0 = got_q.size(); p0 = pops; pb0 = pop_bad; sb0 = stab_bad;
        er0 = n_err; ab0 = n_abort; dn0 = n_done; ea0 = n_errab;
        bz0 = busy_cnt;
        rmode = rm;
        @(posedge clk); #1;
        pid = p; pkt_len = 7'(len); start_tx = 1'b1;
        @(posedge clk); #1;
        start_tx = 1'b0; pid = 4'($urandom); pkt_len = 7'($urandom);
        chk("latency", 32'(tx_valid), 32'(legal));
        to = 1'b1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (poke && k == 1) begin
                pid = 4'b0010;
                start_tx = 1'b1;
            end else if (poke && k == 2) begin
                start_tx = 1'b0;
            end
            if (!busy) begin
                to = 1'b0;
                break;
            end
        end
        start_tx = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("timeout", 32'(to), 0);
        chk("nbytes", got_q.size() - g0, eq.size());
        m = (got_q.size() - g0 < eq.size()) ? got_q.size() - g0 : eq.size();
        for (int i = 0; i < m; i++) begin
            chk($sformatf("byte%0d", i), 32'(got_q[g0+i]), 32'(eq[i]));
            chk($sformatf("last%0d", i), 32'(last_q[g0+i]),
                32'(e_done && i == eq.size() - 1));
        end
        chk("pops", pops - p0, e_pops);
        chk("pop_no_accept", pop_bad - pb0, 0);
        chk("stall_stable", stab_bad - sb0, 0);
        chk("err", n_err - er0, 32'(e_err));
        chk("abort", n_abort - ab0, 32'(e_ab));
        chk("err_with_abort", n_errab - ea0, 32'(e_ab));
        chk("done", n_done - dn0, 32'(e_done));
        if (!legal) chk("busy_illegal", busy_cnt - bz0, 0);
    endtask

    logic [7:0] dq [$];
    int p0;
    bit to6;

    initial begin
        rmode = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outs", {tx_valid, tx_last, tx_abort, busy, done, err,
                         fifo_r_enable, tx_byte}, 0);
        n_rst = 1'b1;
        @(posedge clk); #1;
        chk("idle_outs", {tx_valid, tx_last, tx_abort, busy, done, err,
                          fifo_r_enable, tx_byte}, 0);

        run_pkt(4'b0010, 0, 0, 0, 0, 1'b0);
        run_pkt(4'b0011, 0, 0, 0, 0, 1'b0);
        run_pkt(4'b1011, 4, 4, 1, 1, 1'b0);
        run_pkt(4'b0011, 3, 1, 0, 2, 1'b0);
        run_pkt(4'b0001, 0, 0, 0, 0, 1'b0);
        run_pkt(4'b0011, 65, 0, 0, 0, 1'b0);
        run_pkt(4'b1011, 64, 64, 2, 0, 1'b0);
        run_pkt(4'b0011, 6, 6, 0, 0, 1'b1);

        // asynchronous reset in the middle of the payload
        load_fifo(8, 0, dq);
        rmode = 0;
        @(posedge clk); #1;
        pid = 4'b0011; pkt_len = 7'd8; start_tx = 1'b1;
        @(posedge clk); #1;
        start_tx = 1'b0;
        p0 = pops;
        to6 = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (k == 0) begin
                pid = 4'b0010;
                start_tx = 1'b1;
            end else begin
                start_tx = 1'b0;
            end
            if (pops - p0 >= 2) begin
                to6 = 1'b0;
                break;
            end
        end
        start_tx = 1'b0;
        chk("rst_wait", 32'(to6), 0);
        @(posedge clk); #2;
        chk("busy_before_rst", 32'(busy), 1);
        n_rst = 1'b0;
        #1;
        chk("rst_mid_outs", {tx_valid, tx_last, tx_abort, busy, done, err,
                             fifo_r_enable, tx_byte}, 0);
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b1;
        run_pkt(4'b1011, 5, 5, 0, 0, 1'b0);

        for (int t = 0; t < 30; t++) begin
            int l, na;
            logic [3:0] pr;
            pr = 4'($urandom);
            if ($urandom_range(0, 2) != 0) pr[1:0] = 2'b11;
            l  = $urandom_range(0, 70);
            na = ($urandom_range(0, 1) == 1) ? l : $urandom_range(0, l);
            run_pkt(pr, l, na, $urandom_range(0, 2), 0, 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
